// File: rtl/lsu_pkg.sv
// Shared load/store definitions: op size encodings, store flag position and the
// alignment rule used by the address generation path.
package lsu_pkg;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzRsvd = 2'b11
    } size_e;

    localparam int unsigned STORE_BIT = 4;

    // Reserved size is always flagged so the entry is trapped downstream.
    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b1;
        unique case (size)
            SzByte: mis = 1'b0;
            SzHalf: mis = addr_lo[0];
            SzWord: mis = |addr_lo;
            SzRsvd: mis = 1'b1;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/agu_fifo.sv
// Request queue in front of the AGU: power-of-two ring buffer with a
// registered occupancy count and flush.
module agu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push && rst && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/addr_gen_unit.sv
// Address generation unit: queues requests, then registers base+offset with an
// alignment flag into a single output slot with valid/ready handshake.
module addr_gen_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 3,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_base,
    input  logic [XLEN-1:0]        in_offset,
    input  logic [OP_W-1:0]        in_op,
    input  logic [ROB_W-1:0]       in_rob,
    input  logic [XLEN-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_addr,
    output logic [OP_W-1:0]        out_op,
    output logic [ROB_W-1:0]       out_rob,
    output logic [XLEN-1:0]        out_data,
    output logic                   out_misalign,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned WIDTH = 3 * XLEN + OP_W + ROB_W;

    logic [WIDTH-1:0] wdata, rdata;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [XLEN-1:0]  rd_base, rd_off, rd_data, sum;
    logic [OP_W-1:0]  rd_op;
    logic [ROB_W-1:0] rd_rob;

    logic             out_valid_q, out_mis_q;
    logic [XLEN-1:0]  out_addr_q, out_data_q;
    logic [OP_W-1:0]  out_op_q;
    logic [ROB_W-1:0] out_rob_q;

    // Readiness uses the registered count only; no credit for a same-cycle pop.
    assign in_ready = rst && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid_q || out_ready);
    assign wdata    = {in_base, in_offset, in_op, in_rob, in_data};

    agu_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    assign rd_base = rdata[WIDTH-1 -: XLEN];
    assign rd_off  = rdata[WIDTH-XLEN-1 -: XLEN];
    assign rd_op   = rdata[XLEN+ROB_W +: OP_W];
    assign rd_rob  = rdata[XLEN +: ROB_W];
    assign rd_data = rdata[XLEN-1:0];
    assign sum     = rd_base + rd_off;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_op_q    <= '0;
            out_rob_q   <= '0;
            out_data_q  <= '0;
            out_mis_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= sum;
            out_op_q    <= rd_op;
            out_rob_q   <= rd_rob;
            out_data_q  <= rd_data;
            out_mis_q   <= misaligned(size_e'(rd_op[1:0]), sum[1:0]);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_op       = out_op_q;
    assign out_rob      = out_rob_q;
    assign out_data     = out_data_q;
    assign out_misalign = out_mis_q;
    assign occupancy    = count;

endmodule

// File: tb/tb_addr_gen_unit.sv
// Directed self-checking bench for addr_gen_unit.
module tb_addr_gen_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_misalign;
    logic [31:0] in_base, in_offset, in_data, out_addr, out_data;
    logic [4:0]  in_op, out_op;
    logic [2:0]  in_rob, out_rob;
    logic [2:0]  occupancy;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] OP_B = 5'b00000;
    localparam logic [4:0] OP_H = 5'b00001;
    localparam logic [4:0] OP_W = 5'b00010;

    addr_gen_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_base      (in_base),
        .in_offset    (in_offset),
        .in_op        (in_op),
        .in_rob       (in_rob),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_op       (out_op),
        .out_rob      (out_rob),
        .out_data     (out_data),
        .out_misalign (out_misalign),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [31:0] o, input logic [4:0] op,
                         input logic [2:0] rob, input logic [31:0] d);
        in_valid  = 1'b1;
        in_base   = b;
        in_offset = o;
        in_op     = op;
        in_rob    = rob;
        in_data   = d;
    endtask

    initial begin
        logic [4:0] st_rsvd;
        st_rsvd = 5'b00011;
        st_rsvd[STORE_BIT] = 1'b1;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_base = '0; in_offset = '0; in_op = '0; in_rob = '0; in_data = '0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_in_ready_low", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1);

        // Basic word load, two-edge latency
        out_ready = 1'b1;
        drive(32'h1000, 32'h24, OP_W, 3'd5, 32'hCAFE_0001);
        step();
        in_valid = 1'b0;
        chk("lat_edge1_valid", out_valid, 0);
        chk("lat_edge1_occ", occupancy, 1);
        step();
        chk("lat_edge2_valid", out_valid, 1);
        chk("basic_addr", out_addr, 32'h1024);
        chk("basic_rob", out_rob, 5);
        chk("basic_mis", out_misalign, 0);
        chk("basic_data", out_data, 32'hCAFE_0001);
        chk("basic_op", out_op, OP_W);
        step();
        chk("basic_drain", out_valid, 0);

        // Address wrap, then reserved size store
        drive(32'hFFFF_FFFE, 32'h4, OP_H, 3'd1, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_addr", out_addr, 32'h2);
        chk("wrap_mis", out_misalign, 0);
        drive(32'h2000, 32'h0, st_rsvd, 3'd3, 32'h55);
        step();
        in_valid = 1'b0;
        chk("rsvd_gap_valid", out_valid, 0);
        step();
        chk("rsvd_mis", out_misalign, 1);
        chk("rsvd_op", out_op, 5'h13);
        step();

        // Misaligned word then byte at same address
        drive(32'h1001, 32'h0, OP_W, 3'd1, 32'h0);
        step();
        drive(32'h1001, 32'h0, OP_B, 3'd2, 32'h0);
        step();
        in_valid = 1'b0;
        chk("misw_rob", out_rob, 1);
        chk("misw_mis", out_misalign, 1);
        step();
        chk("misb_rob", out_rob, 2);
        chk("misb_mis", out_misalign, 0);
        chk("misb_valid", out_valid, 1);
        step();
        chk("mis_drain", out_valid, 0);

        // Backpressure: hold one entry in output, fill queue, fifth entry waits
        out_ready = 1'b0;
        drive(32'h500, 32'h0, OP_W, 3'd7, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("bp_hold_rob", out_rob, 7);
        for (int i = 1; i <= 4; i++) begin
            drive(32'h100 * i, 32'h0, OP_W, 3'(i), 32'(i));
            step();
        end
        chk("bp_full_occ", occupancy, 4);
        chk("bp_full_ready", in_ready, 0);
        drive(32'h600, 32'h0, OP_W, 3'd5, 32'h5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall_ready", in_ready, 0);
            chk("bp_stall_occ", occupancy, 4);
            chk("bp_stable_addr", out_addr, 32'h500);
            chk("bp_stable_rob", out_rob, 7);
        end
        out_ready = 1'b1;
        step();
        chk("bp_rel_rob1", out_rob, 1);
        chk("bp_rel_occ3", occupancy, 3);
        chk("bp_rel_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_rel_rob2", out_rob, 2);
        chk("bp_pushpop_occ", occupancy, 3);
        step();
        chk("bp_rel_rob3", out_rob, 3);
        step();
        chk("bp_rel_rob4", out_rob, 4);
        chk("bp_rel_addr4", out_addr, 32'h400);
        step();
        chk("bp_rel_rob5", out_rob, 5);
        chk("bp_rel_addr5", out_addr, 32'h600);
        chk("bp_rel_occ0", occupancy, 0);
        step();
        chk("bp_drain", out_valid, 0);

        // Flush with three queued entries and a push attempt
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h3000, 32'(i * 4), OP_W, 3'(i), 32'h0);
            step();
        end
        chk("fl_pre_occ", occupancy, 3);
        drive(32'h4000, 32'h0, OP_W, 3'd6, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_absent", out_valid, 0);
        end

        // Reset during streaming
        drive(32'h10, 32'h0, OP_W, 3'd1, 32'h11);
        step();
        drive(32'h20, 32'h0, OP_W, 3'd2, 32'h22);
        step();
        chk("rs_stream_rob1", out_rob, 1);
        drive(32'h30, 32'h0, OP_W, 3'd3, 32'h33);
        rst = 1'b0;
        step();
        chk("rs_valid", out_valid, 0);
        chk("rs_addr", out_addr, 0);
        chk("rs_rob", out_rob, 0);
        chk("rs_data", out_data, 0);
        chk("rs_op", out_op, 0);
        chk("rs_mis", out_misalign, 0);
        chk("rs_occ", occupancy, 0);
        chk("rs_ready_low", in_ready, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rs_ready_release", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_no_stale", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_gen_unit.md
ADDR_GEN_UNIT -- requirements
Module: addr_gen_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/address/data width.
REQ-002 SHALL have parameter ROB_W, default 3, ROB tag width.
REQ-003 SHALL have parameter OP_W, default 5, op width (min 5).
REQ-004 SHALL have parameter DEPTH, default 4, input queue entries (power of two, >=2).
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port flush  in  1  discard all queued and output-held entries.
REQ-008 SHALL have port in_valid  in  1  request present.
REQ-009 SHALL have port in_ready  out  1  queue can accept.
REQ-010 SHALL have port in_base, in_offset  in  XLEN each  address operands.
REQ-011 SHALL have port in_op  in  OP_W  op; [1:0] size (00 B, 01 H, 10 W, 11 reserved), [4] store.
REQ-012 SHALL have port in_rob  in  ROB_W  ROB tag.
REQ-013 SHALL have port in_data  in  XLEN  store data, passed through.
REQ-014 SHALL have port out_valid  in/out: out  1  result held.
REQ-015 SHALL have port out_ready  in  1  consumer takes result.
REQ-016 SHALL have ports out_addr XLEN, out_op OP_W, out_rob ROB_W, out_data XLEN  outputs  result fields.
REQ-017 SHALL have port out_misalign  out  1  address not aligned to size, or size 11.
REQ-018 SHALL have port occupancy  out  clog2(DEPTH)+1  queued entries (excl. output reg).

Function
REQ-019 Push SHALL occur on in_valid & in_ready; in_ready = (occupancy < DEPTH), registered count only, no same-cycle pop credit.
REQ-020 Queue SHALL be FIFO with read/write pointers wrapping modulo DEPTH; order preserved.
REQ-021 Output register SHALL load queue head when queue non-empty and (!out_valid or out_ready); pop and load same edge.
REQ-022 Output transfer SHALL occur on out_valid & out_ready; with empty queue out_valid clears next edge.
REQ-023 out_addr SHALL be (base + offset) modulo 2^XLEN, computed at load; no carry out.
REQ-024 out_misalign SHALL be: H and addr[0]; W and addr[1:0]!=0; size 11 always; B never. Entry still delivered.
REQ-025 Latency SHALL be 2 edges push-to-out_valid; sustained throughput 1 entry/cycle with out_ready held high.
REQ-026 Output fields SHALL hold stable while out_valid & !out_ready.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged; full queue SHALL keep in_ready low until a pop.
REQ-028 flush SHALL, at the edge, empty queue, clear out_valid, reset pointers; push attempted that cycle is dropped.
REQ-029 flush SHALL have priority below rst, above push/pop/load.

Reset
REQ-030 On rst low at edge: out_valid 0, out_addr 0, out_op 0, out_rob 0, out_data 0, out_misalign 0, occupancy 0, pointers 0.
REQ-031 rst low mid-operation SHALL discard all entries; in_ready SHALL read 0 while rst low, 1 first cycle after release.
REQ-032 Queue storage array SHALL need no reset.

Structure
REQ-033 Op size encodings, store bit index and misalign function SHALL live in shared package lsu_pkg.
REQ-034 Queue SHALL be sub-module agu_fifo (parameters WIDTH, DEPTH); alignment check and adder in top.

Verification
REQ-035 Reset then push base 0x1000, off 0x24, op W load, rob 5 -> out_valid edge 2, addr 0x1024, rob 5, misalign 0.
REQ-036 Push base 0xFFFFFFFE, off 0x4, op H -> addr 0x00000002, misalign 0 (wrap).
REQ-037 Push base 0x1001, off 0, op W; then op B same addr -> misalign 1 then 0, both delivered in order.
REQ-038 out_ready 0, push 5 entries -> 4 accepted, in_ready 0 after 4th (occupancy 4), output held stable; release -> 5 in order.
REQ-039 Queue 3 entries, flush with in_valid high -> next cycle out_valid 0, occupancy 0, pushed entry absent.
REQ-040 rst low for 1 cycle during streaming -> all outputs zero, occupancy 0, no stale entry emitted afterward.
